// File: rtl/gpio_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the GPIO slave between NUM_MASTERS masters.
// Optional stall timeout: define GPIO_ARB_TIMEOUT_EN.
module gpio_wb_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADR_W          = 5,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_ni,
   input  logic [NUM_MASTERS-1:0]       m_cyc_i,
   input  logic [NUM_MASTERS-1:0]       m_stb_i,
   input  logic [NUM_MASTERS-1:0]       m_we_i,
   input  logic [NUM_MASTERS*ADR_W-1:0] m_adr_i,
   input  logic [NUM_MASTERS*32-1:0]    m_dat_i,
   input  logic [NUM_MASTERS*4-1:0]     m_sel_i,
   output logic [31:0]                  m_dat_o,
   output logic [NUM_MASTERS-1:0]       m_ack_o,
   output logic [NUM_MASTERS-1:0]       m_err_o,
   output logic                         s_cyc_o,
   output logic                         s_stb_o,
   output logic                         s_we_o,
   output logic [ADR_W-1:0]             s_adr_o,
   output logic [31:0]                  s_dat_o,
   output logic [3:0]                   s_sel_o,
   input  logic [31:0]                  s_dat_i,
   input  logic                         s_ack_i,
   input  logic                         s_err_i,
   output logic [NUM_MASTERS-1:0]       grant_o
);
   localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state;
   logic [NUM_MASTERS-1:0] grant;
   logic [PW-1:0]          ptr;
   logic [PW-1:0]          pick;
   logic [PW-1:0]          nxt;
   logic [NUM_MASTERS-1:0] rot;
   logic                   found;
   logic                   cyc_g;
   logic                   stb_g;
   logic                   timeout;
   int                     off;

   assign cyc_g   = |(m_cyc_i & grant);
   assign stb_g   = |(m_stb_i & grant);
   assign grant_o = grant;
   assign m_dat_o = s_dat_i;

   // Rotate requests so bit 0 is the rr pointer; lowest set bit wins.
   always_comb begin
      rot   = NUM_MASTERS'({m_cyc_i, m_cyc_i} >> ptr);
      found = |m_cyc_i;
      off   = 0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
         if (rot[i]) off = i;
      pick = PW'((int'(ptr) + off) % NUM_MASTERS);
   end

   always_comb begin
      nxt = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (grant[i]) nxt = PW'((i + 1) % NUM_MASTERS);
   end

   // grant is all-zero in IDLE, so every routed output is quiet there.
   always_comb begin
      s_cyc_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant[i]) begin
            s_cyc_o = m_cyc_i[i];
            s_we_o  = m_we_i[i];
            s_adr_o = m_adr_i[i*ADR_W +: ADR_W];
            s_dat_o = m_dat_i[i*32 +: 32];
            s_sel_o = m_sel_i[i*4 +: 4];
         end
      end
      s_stb_o = stb_g & ~timeout;
      m_ack_o = grant & {NUM_MASTERS{s_ack_i}};
      m_err_o = grant & {NUM_MASTERS{s_err_i | timeout}};
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               state <= BUSY;
               grant <= NUM_MASTERS'(1) << pick;
            end
            BUSY: if (!cyc_g) begin
               state <= IDLE;
               grant <= '0;
               ptr   <= nxt;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GPIO_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   logic          stall;

   assign stall   = (state == BUSY) && stb_g && !s_ack_i && !s_err_i;
   assign timeout = stall && (cnt == CW'(TIMEOUT_CYCLES - 1));

   // Stb-low gaps inside a locked cycle hold the count rather than clear it.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)
         cnt <= '0;
      else if (state != BUSY || s_ack_i || s_err_i || timeout)
         cnt <= '0;
      else if (stall)
         cnt <= cnt + CW'(1);
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Directed scoreboard bench for gpio_wb_arbiter with two masters and a model GPIO slave.
module tb_gpio_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
   logic [9:0]  m_adr = '0;
   logic [63:0] m_dat = '0;
   logic [7:0]  m_sel = '0;
   logic [31:0] m_dat_o;
   logic [1:0]  m_ack_o, m_err_o, grant_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [4:0]  s_adr_o;
   logic [31:0] s_dat_o, s_dat_i;
   logic [3:0]  s_sel_o;
   logic        s_ack = 1'b0;
   logic        slv_en = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          m;
      logic        we;
      logic [4:0]  adr;
      logic [31:0] dat;
   } exp_t;
   exp_t sb[$];

   gpio_wb_arbiter dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
      .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack), .s_err_i(1'b0), .grant_o(grant_o)
   );

   always #5 clk = ~clk;

   // Model slave: one-cycle registered ack, read data derived from address.
   assign s_dat_i = 32'h0000_1234 + {27'h0, s_adr_o};
   always @(posedge clk or negedge rst_n)
      if (!rst_n) s_ack <= 1'b0;
      else        s_ack <= slv_en && s_cyc_o && s_stb_o && !s_ack;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every slave-side completed beat must match the next expectation.
   always @(negedge clk) begin
      if (rst_n && s_cyc_o && s_stb_o && s_ack) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", 32'(grant_o), 32'h0);
         end else begin
            exp_t e;
            logic [1:0] g;
            e = sb.pop_front();
            g = 2'b01 << e.m;
            chk("sb_grant", 32'(grant_o), 32'(g));
            chk("sb_ack", 32'(m_ack_o), 32'(g));
            chk("sb_err", 32'(m_err_o), 32'h0);
            chk("sb_we", 32'(s_we_o), 32'(e.we));
            chk("sb_adr", 32'(s_adr_o), 32'(e.adr));
            if (e.we) chk("sb_wdat", s_dat_o, e.dat);
            else      chk("sb_rdat", m_dat_o, 32'h0000_1234 + 32'(e.adr));
         end
      end
   end

   task automatic drive(input int i, input logic we, input logic [4:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
      m_cyc[i] = 1'b1;
      m_stb[i] = 1'b1;
      m_we[i]  = we;
      m_adr[i*5 +: 5]   = adr;
      m_dat[i*32 +: 32] = dat;
      m_sel[i*4 +: 4]   = sel;
   endtask

   task automatic push(input int i, input logic we, input logic [4:0] adr, input logic [31:0] dat);
      exp_t e;
      e.m = i; e.we = we; e.adr = adr; e.dat = dat;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input int i);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_ack_o[i] && n < 40);
      chk($sformatf("ack_wait_m%0d", i), 32'(m_ack_o[i]), 32'h1);
   endtask

   task automatic release_m(input int i);
      @(posedge clk); #1;
      m_cyc[i] = 1'b0;
      m_stb[i] = 1'b0;
      m_we[i]  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n, first, nerr;
      logic stb_at_err;

      // reset state
      @(negedge clk);
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_scyc", 32'(s_cyc_o), 32'h0);
      chk("rst_sstb", 32'(s_stb_o), 32'h0);
      chk("rst_ack", 32'(m_ack_o), 32'h0);
      chk("rst_err", 32'(m_err_o), 32'h0);
      idle(2);
      rst_n = 1'b1;

      // 1: single write from m0
      idle(1);
      drive(0, 1'b1, 5'h04, 32'hA5, 4'h1);
      push(0, 1'b1, 5'h04, 32'hA5);
      @(negedge clk);
      chk("t1_lat_grant", 32'(grant_o), 32'h0);
      @(negedge clk);
      chk("t1_grant", 32'(grant_o), 32'h1);
      chk("t1_we", 32'(s_we_o), 32'h1);
      chk("t1_dat", s_dat_o, 32'hA5);
      chk("t1_sel", 32'(s_sel_o), 32'h1);
      wait_ack(0);
      release_m(0);
      @(negedge clk);
      chk("t1_ack_pulse", 32'(m_ack_o), 32'h0);
      idle(2);

      // 2: simultaneous requests right after reset
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      drive(0, 1'b1, 5'h01, 32'h11, 4'hF);
      drive(1, 1'b1, 5'h02, 32'h22, 4'hF);
      push(0, 1'b1, 5'h01, 32'h11);
      push(1, 1'b1, 5'h02, 32'h22);
      wait_ack(0);
      release_m(0);
      @(negedge clk);
      @(negedge clk);
      chk("t2_idle_grant", 32'(grant_o), 32'h0);
      chk("t2_idle_scyc", 32'(s_cyc_o), 32'h0);
      @(negedge clk);
      chk("t2_m1_grant", 32'(grant_o), 32'h2);
      wait_ack(1);
      release_m(1);
      idle(2);
      drive(0, 1'b1, 5'h03, 32'h33, 4'hF);
      drive(1, 1'b1, 5'h05, 32'h55, 4'hF);
      push(0, 1'b1, 5'h03, 32'h33);
      push(1, 1'b1, 5'h05, 32'h55);
      wait_ack(0);
      release_m(0);
      wait_ack(1);
      release_m(1);
      idle(2);

      // 3+4: locked 3-beat m0 sequence, m1 read waits
      drive(0, 1'b1, 5'h04, 32'h1111, 4'hF);
      push(0, 1'b1, 5'h04, 32'h1111);
      push(0, 1'b1, 5'h08, 32'h2222);
      push(0, 1'b1, 5'h0C, 32'h3333);
      push(1, 1'b0, 5'h00, 32'h0);
      idle(1);
      drive(1, 1'b0, 5'h00, 32'h0, 4'hF);
      wait_ack(0);
      chk("t3_lock1", 32'(grant_o), 32'h1);
      idle(1);
      drive(0, 1'b1, 5'h08, 32'h2222, 4'hF);
      wait_ack(0);
      chk("t3_lock2", 32'(grant_o), 32'h1);
      idle(1);
      drive(0, 1'b1, 5'h0C, 32'h3333, 4'hF);
      wait_ack(0);
      chk("t3_lock3", 32'(grant_o), 32'h1);
      release_m(0);
      wait_ack(1);
      chk("t4_rdata", m_dat_o, 32'h0000_1234);
      chk("t4_ack", 32'(m_ack_o), 32'h2);
      release_m(1);
      idle(2);

      // 5: async reset mid-transaction clears grant and pointer
      drive(0, 1'b1, 5'h10, 32'h77, 4'hF);
      push(0, 1'b1, 5'h10, 32'h77);
      wait_ack(0);
      release_m(0);
      idle(2);
      drive(1, 1'b1, 5'h14, 32'h88, 4'hF);
      @(negedge clk);
      @(negedge clk);
      chk("t5_pre_grant", 32'(grant_o), 32'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_scyc", 32'(s_cyc_o), 32'h0);
      chk("t5_rst_grant", 32'(grant_o), 32'h0);
      chk("t5_rst_ack", 32'(m_ack_o), 32'h0);
      m_cyc = '0;
      m_stb = '0;
      idle(1);
      rst_n = 1'b1;
      drive(0, 1'b0, 5'h04, 32'h0, 4'hF);
      drive(1, 1'b0, 5'h08, 32'h0, 4'hF);
      push(0, 1'b0, 5'h04, 32'h0);
      push(1, 1'b0, 5'h08, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("t5_fresh_grant", 32'(grant_o), 32'h1);
      wait_ack(0);
      release_m(0);
      wait_ack(1);
      release_m(1);
      idle(2);

      // 6: hung slave
      slv_en = 1'b0;
      drive(0, 1'b1, 5'h1C, 32'h99, 4'hF);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!grant_o[0] && n < 10);
      first = 0;
      nerr = 0;
      stb_at_err = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         if (m_err_o[0]) begin
            nerr++;
            if (first == 0) first = c;
            stb_at_err = s_stb_o;
         end
         @(negedge clk);
      end
      chk("t6_grant_held", 32'(grant_o), 32'h1);
      chk("t6_no_ack", 32'(m_ack_o), 32'h0);
`ifdef GPIO_ARB_TIMEOUT_EN
      chk("t6_err_cycle", 32'(first), 32'd16);
      chk("t6_err_count", 32'(nerr), 32'd1);
      chk("t6_stb_masked", 32'(stb_at_err), 32'h0);
`else
      chk("t6_err_cycle", 32'(first), 32'd0);
      chk("t6_err_count", 32'(nerr), 32'd0);
`endif
      release_m(0);
      slv_en = 1'b1;
      idle(3);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
